ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low hold before request (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum frame duration after clock release (20 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock (CLOCK_50).
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port tx_data  input  8  command byte to send to the keyboard (e.g. 0xED, 0xFF).
REQ-006 SHALL have port tx_start  input  1  one-cycle request; tx_data is captured in the same cycle.
REQ-007 SHALL have port ps2_clk_in  input  1  raw PS/2 clock line level (asynchronous).
REQ-008 SHALL have port ps2_data_in  input  1  raw PS/2 data line level (asynchronous).
REQ-009 SHALL have port ps2_clk_oe  output  1  1 = drive the PS/2 clock low; 0 = release it.
REQ-010 SHALL have port ps2_data_oe  output  1  1 = drive the PS/2 data low; 0 = release it.
REQ-011 SHALL have port tx_busy  output  1  high from accept until DONE/ERROR; the receiver ignores the line while it is high.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse on acknowledged completion.
REQ-013 SHALL have port tx_error  output  1  one-cycle pulse on missing acknowledge or timeout.

Function
REQ-014 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers; a falling edge is synced clock 1 -> 0 between consecutive cycles.
REQ-015 SHALL implement states IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE, DONE, ERROR.
REQ-016 IDLE: outputs released and tx_busy=0; tx_start=1 latches tx_data and the odd parity (~^tx_data), then moves to INHIBIT on the next cycle.
REQ-017 IDLE SHALL ignore tx_start outside IDLE, with no effect on the transfer in progress.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe=1 during the final cycle; then go to REQUEST.
REQ-019 REQUEST: ps2_clk_oe=0 and ps2_data_oe=1 (start bit); clear the bit counter and timeout counter; the first falling edge goes to SHIFT.
REQ-020 SHIFT: on falling edges 1-8, present data bits D0..D7 LSB first; on edge 9 present parity; on edge 10 present the stop bit (released).
REQ-021 SHIFT: each bit SHALL be driven as ps2_data_oe = ~bit, updated the cycle after the falling edge is detected.
REQ-022 After the 10th falling edge the block SHALL go to ACK with ps2_data_oe=0.
REQ-023 ACK: on the 11th falling edge, sample synced data: 0 -> WAIT_IDLE; 1 -> ERROR.
REQ-024 WAIT_IDLE: wait until synced clock and data are both 1, then go to DONE.
REQ-025 DONE: pulse tx_done for 1 cycle, then go to IDLE.
REQ-026 ERROR: pulse tx_error for 1 cycle, release both lines, then go to IDLE.
REQ-027 The 20-bit timeout counter SHALL run in REQUEST, SHIFT, ACK and WAIT_IDLE; reaching TIMEOUT_CYCLES goes to ERROR, also when an edge arrives in the same cycle.
REQ-028 tx_done and tx_error SHALL never assert in the same cycle; tx_busy SHALL deassert in the cycle after the pulse.
REQ-029 INHIBIT counter SHALL be 13 bits; bit counter SHALL be 4 bits, saturating at 11.

Reset
REQ-030 rst=0 at a rising clk edge SHALL force IDLE, clear all counters and set ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_error=0 from the next cycle.
REQ-031 Reset mid-transfer SHALL release both lines immediately; no done or error pulse is produced.
REQ-032 The first cycle after reset deasserts SHALL accept tx_start.

Verification
REQ-033 Send 0xED with a device model ack -> data bits seen 1,0,1,1,0,1,1,1, parity 1, stop released; tx_done 1 pulse; tx_busy low after.
REQ-034 Send 0x01 and 0x00 -> parity 0 and 1 respectively; 0xFF -> parity 1; each ends with tx_done.
REQ-035 Device holds data high on the 11th edge -> tx_error 1 pulse, no tx_done, lines released.
REQ-036 Device never clocks -> tx_error exactly TIMEOUT_CYCLES cycles after entering REQUEST (parameter overridden to 1000 in simulation).
REQ-037 rst=0 at the 5th falling edge -> next cycle ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0; a new 0xF4 send then completes.
REQ-038 tx_start pulsed with 0x55 during SHIFT of 0xED -> transmitted byte remains 0xED; exactly one tx_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Inhibits the bus, issues a request-to-send, shifts a command byte plus odd
// parity and stop bit on device-generated clock edges, then checks the
// device acknowledge. The PS/2 lines are open-drain: an _oe of 1 pulls the
// line low, 0 releases it.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQUEST,
      SHIFT,
      ACK,
      WAIT_IDLE,
      DONE,
      ERROR
   } state_t;

   // Last inhibit count, and the count on which data is pulled low so that it
   // is already low during the final inhibit cycle. When INHIBIT_CYCLES is 1
   // the data-low count never matches; the IDLE exit handles that case.
   localparam logic [12:0] INH_LAST = 13'(INHIBIT_CYCLES - 1);
   localparam logic [12:0] INH_DATA = 13'(INHIBIT_CYCLES - 2);
   localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);
   localparam logic        INH_ONE  = (INHIBIT_CYCLES == 1);

   state_t      state_reg;
   logic [12:0] inh_cnt_reg;
   logic [3:0]  bit_cnt_reg;
   logic [19:0] to_cnt_reg;
   logic [7:0]  data_reg;
   logic        parity_reg;
   logic        clk_oe_reg;
   logic        data_oe_reg;
   logic        busy_reg;
   logic        done_reg;
   logic        error_reg;

   logic [1:0]  clk_sync_reg;
   logic [1:0]  data_sync_reg;
   logic        clk_prev_reg;

   logic        clk_fall;
   logic        clk_synced;
   logic        data_synced;
   logic        timed_out;
   logic [3:0]  bit_cnt_inc;

   assign clk_synced  = clk_sync_reg[1];
   assign data_synced = data_sync_reg[1];
   assign clk_fall    = clk_prev_reg & ~clk_synced;
   assign timed_out   = (to_cnt_reg == TO_LAST);
   assign bit_cnt_inc = (bit_cnt_reg == 4'd11) ? 4'd11 : bit_cnt_reg + 4'd1;

   assign ps2_clk_oe  = clk_oe_reg;
   assign ps2_data_oe = data_oe_reg;
   assign tx_busy     = busy_reg;
   assign tx_done     = done_reg;
   assign tx_error    = error_reg;

   // Two-flop synchronizers plus the previous synced clock for edge detection;
   // lines idle high, so reset to 1 to avoid a phantom falling edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_sync_reg  <= 2'b11;
         data_sync_reg <= 2'b11;
         clk_prev_reg  <= 1'b1;
      end else begin
         clk_sync_reg  <= {clk_sync_reg[0], ps2_clk_in};
         data_sync_reg <= {data_sync_reg[0], ps2_data_in};
         clk_prev_reg  <= clk_synced;
      end
   end

   // Transmit sequencer with registered line drives and status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         inh_cnt_reg <= '0;
         bit_cnt_reg <= '0;
         to_cnt_reg  <= '0;
         data_reg    <= '0;
         parity_reg  <= 1'b0;
         clk_oe_reg  <= 1'b0;
         data_oe_reg <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         error_reg   <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         error_reg <= 1'b0;
         unique case (state_reg)
            IDLE: begin
               clk_oe_reg  <= 1'b0;
               data_oe_reg <= 1'b0;
               busy_reg    <= 1'b0;
               if (tx_start) begin
                  data_reg    <= tx_data;
                  parity_reg  <= ~^tx_data;
                  inh_cnt_reg <= '0;
                  clk_oe_reg  <= 1'b1;
                  data_oe_reg <= INH_ONE;
                  busy_reg    <= 1'b1;
                  state_reg   <= INHIBIT;
               end
            end
            INHIBIT: begin
               inh_cnt_reg <= inh_cnt_reg + 13'd1;
               if (inh_cnt_reg == INH_DATA) begin
                  data_oe_reg <= 1'b1;
               end
               if (inh_cnt_reg == INH_LAST) begin
                  clk_oe_reg  <= 1'b0;
                  data_oe_reg <= 1'b1;
                  bit_cnt_reg <= '0;
                  to_cnt_reg  <= '0;
                  state_reg   <= REQUEST;
               end
            end
            REQUEST, SHIFT, ACK, WAIT_IDLE: begin
               to_cnt_reg <= to_cnt_reg + 20'd1;
               // Timeout wins over any edge arriving in the same cycle.
               if (timed_out) begin
                  clk_oe_reg  <= 1'b0;
                  data_oe_reg <= 1'b0;
                  error_reg   <= 1'b1;
                  state_reg   <= ERROR;
               end else begin
                  unique case (state_reg)
                     REQUEST: begin
                        if (clk_fall) begin
                           bit_cnt_reg <= 4'd1;
                           data_oe_reg <= ~data_reg[0];
                           state_reg   <= SHIFT;
                        end
                     end
                     SHIFT: begin
                        // bit_cnt_reg holds the number of edges seen so far.
                        if (clk_fall) begin
                           bit_cnt_reg <= bit_cnt_inc;
                           if (bit_cnt_reg < 4'd8) begin
                              data_oe_reg <= ~data_reg[bit_cnt_reg[2:0]];
                           end else if (bit_cnt_reg == 4'd8) begin
                              data_oe_reg <= ~parity_reg;
                           end else begin
                              data_oe_reg <= 1'b0;
                              state_reg   <= ACK;
                           end
                        end
                     end
                     ACK: begin
                        if (clk_fall) begin
                           bit_cnt_reg <= bit_cnt_inc;
                           if (!data_synced) begin
                              state_reg <= WAIT_IDLE;
                           end else begin
                              clk_oe_reg  <= 1'b0;
                              data_oe_reg <= 1'b0;
                              error_reg   <= 1'b1;
                              state_reg   <= ERROR;
                           end
                        end
                     end
                     WAIT_IDLE: begin
                        if (clk_synced && data_synced) begin
                           done_reg  <= 1'b1;
                           state_reg <= DONE;
                        end
                     end
                     default: begin
                     end
                  endcase
               end
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            ERROR: begin
               clk_oe_reg  <= 1'b0;
               data_oe_reg <= 1'b0;
               busy_reg    <= 1'b0;
               state_reg   <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: an open-drain device model clocks frames and
// records line levels; a scoreboard queue holds the expected outcome of each
// transfer and a negedge monitor checks every done/error pulse against it.
module tb_ps2_host_tx;

   localparam int INH  = 50;
   localparam int TO   = 1000;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       dev_clk;
   logic       dev_data;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   always #5 clk = ~clk;

   // Wired-AND of the open-drain lines.
   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error)
   );

   typedef struct {
      bit          is_error;
      bit          chk_frame;
      logic [10:0] frame;
      int          latency;
   } exp_t;

   typedef struct {
      logic [7:0] d;
      bit         par;
      bit         ack;
   } vec_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   vec_t        vecs[5];
   int          n_vec = 0;
   int          n_fail = 0;
   logic [10:0] last_frame = '0;
   int          cyc = 0;
   int          req_cyc = 0;
   bit          post_pending = 1'b0;
   logic        prev_clk_oe = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: pops one expectation per done/error pulse.
   always @(negedge clk) begin
      cyc++;
      if (prev_clk_oe === 1'b1 && ps2_clk_oe === 1'b0) req_cyc = cyc;
      prev_clk_oe = ps2_clk_oe;
      if (post_pending) begin
         post_pending = 1'b0;
         check("post_busy", {31'd0, tx_busy}, 32'd0);
         check("post_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
         check("post_data_oe", {31'd0, ps2_data_oe}, 32'd0);
         check("post_pulse_low", {30'd0, tx_done, tx_error}, 32'd0);
      end
      if (tx_done === 1'b1 || tx_error === 1'b1) begin
         check("done_error_exclusive", {31'd0, tx_done & tx_error}, 32'd0);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_pulse: got done=%b error=%b, required no pulse", tx_done, tx_error);
         end else begin
            mon_e = exp_q.pop_front();
            $display("pulse at cycle %0d: done=%b error=%b frame=0x%03h", cyc, tx_done, tx_error, last_frame);
            check("pulse_error", {31'd0, tx_error}, {31'd0, mon_e.is_error});
            check("pulse_done", {31'd0, tx_done}, {31'd0, !mon_e.is_error});
            if (mon_e.chk_frame) check("frame_bits", {21'd0, last_frame}, {21'd0, mon_e.frame});
            if (mon_e.latency >= 0) check("timeout_latency", cyc - req_cyc, mon_e.latency);
         end
         post_pending = 1'b1;
      end
   end

   // Device model: waits for request-to-send, then clocks n_edges falling
   // edges, sampling the data line before each rising edge.
   task automatic device_frame(input int n_edges, input bit ack);
      bit found = 1'b0;
      last_frame = '0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(posedge clk);
         #1;
         if (ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) found = 1'b1;
      end
      if (!found) begin
         n_vec++;
         n_fail++;
         $display("FAIL request_wait: got no request, required clk released with data low");
         return;
      end
      wait_cyc(5);
      last_frame[0] = ps2_data_in;
      for (int e = 1; e <= n_edges; e++) begin
         dev_clk = 1'b0;
         if (e == n_edges && n_edges < 11) begin
            wait_cyc(4);
            return;
         end
         wait_cyc(HALF);
         if (e <= 10) last_frame[e] = ps2_data_in;
         dev_clk = 1'b1;
         if (e == 10 && ack) dev_data = 1'b0;
         wait_cyc(HALF);
      end
      dev_data = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      tx_data  = b;
      tx_start = 1'b1;
      wait_cyc(1);
      tx_start = 1'b0;
      check("busy_on_accept", {31'd0, tx_busy}, 32'd1);
   endtask

   task automatic drain(input string name, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (exp_q.size() == 0 && tx_busy === 1'b0) ok = 1'b1;
         else wait_cyc(1);
      end
      if (!ok) begin
         n_vec++;
         n_fail++;
         $display("FAIL %s_drain: got %0d pending outcomes busy=%b, required none", name, exp_q.size(), tx_busy);
         exp_q.delete();
      end
      wait_cyc(3);
   endtask

   task automatic run_vector(input logic [7:0] d, input bit par, input bit ack);
      exp_t e;
      e.is_error  = !ack;
      e.chk_frame = 1'b1;
      e.frame     = {1'b1, par, d, 1'b0};
      e.latency   = -1;
      exp_q.push_back(e);
      fork
         device_frame(11, ack);
         send(d);
      join
      drain("vector", 600);
   endtask

   initial begin
      exp_t e;
      rst      = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      vecs[0] = '{8'hED, 1'b1, 1'b1};
      vecs[1] = '{8'h01, 1'b0, 1'b1};
      vecs[2] = '{8'h00, 1'b1, 1'b1};
      vecs[3] = '{8'hFF, 1'b1, 1'b1};
      vecs[4] = '{8'hED, 1'b1, 1'b0};

      wait_cyc(3);
      check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      check("rst_done", {31'd0, tx_done}, 32'd0);
      check("rst_error", {31'd0, tx_error}, 32'd0);
      rst = 1'b1;

      // First send starts in the first cycle after reset release.
      for (int i = 0; i < 5; i++) run_vector(vecs[i].d, vecs[i].par, vecs[i].ack);

      // Device never clocks: error exactly TO cycles after request.
      e.is_error  = 1'b1;
      e.chk_frame = 1'b0;
      e.frame     = '0;
      e.latency   = TO;
      exp_q.push_back(e);
      send(8'hFF);
      drain("timeout", 3000);

      // Reset at the 5th falling edge, then a clean 0xF4 send.
      fork
         device_frame(5, 1'b1);
         send(8'hED);
      join
      rst     = 1'b0;
      dev_clk = 1'b1;
      wait_cyc(1);
      check("midrst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      check("midrst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
      check("midrst_busy", {31'd0, tx_busy}, 32'd0);
      rst = 1'b1;
      wait_cyc(2);
      run_vector(8'hF4, 1'b0, 1'b1);

      // tx_start with 0x55 during the shift of 0xED must be ignored.
      e.is_error  = 1'b0;
      e.chk_frame = 1'b1;
      e.frame     = {1'b1, 1'b1, 8'hED, 1'b0};
      e.latency   = -1;
      exp_q.push_back(e);
      fork
         device_frame(11, 1'b1);
         send(8'hED);
         begin
            wait_cyc(200);
            tx_data  = 8'h55;
            tx_start = 1'b1;
            wait_cyc(1);
            tx_start = 1'b0;
            tx_data  = 8'h00;
         end
      join
      drain("ignore_start", 600);
      wait_cyc(100);
      check("no_second_transfer", {31'd0, tx_busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, required finish within 2 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
